// File: rtl/alu_commit_arbiter.sv
// alu_commit_arbiter: round-robin retire of ALU results into one writeback stage with sticky exception capture
module alu_commit_arbiter #(
  parameter int N_ALU = 4,
  parameter int XLEN = 32,
  parameter int REG_ADDR_W = 5,
  localparam int PW = $clog2(N_ALU)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_ALU-1:0]            alu_valid,
  input  logic [N_ALU*XLEN-1:0]       alu_res,
  input  logic [N_ALU*REG_ADDR_W-1:0] alu_rd,
  input  logic [N_ALU-1:0]            alu_error,
  output logic [N_ALU-1:0]            alu_clear,
  input  logic                        flush,
  output logic                        wb_en,
  output logic [REG_ADDR_W-1:0]       wb_addr,
  output logic [XLEN-1:0]             wb_data,
  input  logic                        wb_stall,
  output logic                        exc_valid,
  output logic [PW-1:0]               exc_src,
  output logic [REG_ADDR_W-1:0]       exc_rd,
  input  logic                        exc_ack,
  output logic [31:0]                 commit_cnt
);
  logic [XLEN-1:0] res_a [N_ALU];
  logic [REG_ADDR_W-1:0] rd_a [N_ALU];
  logic [N_ALU-1:0] elig, grant_oh;
  logic [PW-1:0] rr_ptr, gidx, idx;
  logic grant, can_grant, g_err, wr;
  logic [XLEN-1:0] g_res;
  logic [REG_ADDR_W-1:0] g_rd;

  for (genvar i = 0; i < N_ALU; i++) begin : g_unpack
    assign res_a[i] = alu_res[i*XLEN +: XLEN];
    assign rd_a[i] = alu_rd[i*REG_ADDR_W +: REG_ADDR_W];
  end

  // an erroring unit must wait until the pending exception is consumed
  assign elig = alu_valid & (~alu_error | {N_ALU{~exc_valid}});
  assign can_grant = (~wb_en | ~wb_stall) & ~flush;

  // scan from rr_ptr downward in rotation distance so the closest eligible unit wins
  always_comb begin
    grant = 1'b0;
    gidx = '0;
    idx = '0;
    for (int k = N_ALU - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr) + k) % N_ALU);
      if (can_grant && elig[idx]) begin
        grant = 1'b1;
        gidx = idx;
      end
    end
  end

  assign g_res = res_a[gidx];
  assign g_rd = rd_a[gidx];
  assign g_err = alu_error[gidx];
  assign wr = grant & ~g_err & (|g_rd);
  assign grant_oh = grant ? N_ALU'(1) << gidx : '0;
  assign alu_clear = rst ? '0 : flush ? alu_valid : grant_oh;

  // round-robin pointer moves past each granted unit
  always_ff @(posedge clk or posedge rst)
    if (rst) rr_ptr <= '0;
    else if (grant) rr_ptr <= gidx == PW'(N_ALU - 1) ? '0 : gidx + 1'b1;

  // writeback stage: flush drops, stall holds, otherwise load or empty
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wb_en <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (flush) wb_en <= 1'b0;
    else if (!(wb_en && wb_stall)) begin
      wb_en <= wr;
      if (wr) begin
        wb_addr <= g_rd;
        wb_data <= g_res;
      end
    end

  // sticky exception; a new error grant takes precedence over the acknowledge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      exc_valid <= 1'b0;
      exc_src <= '0;
      exc_rd <= '0;
    end else if (grant && g_err) begin
      exc_valid <= 1'b1;
      exc_src <= gidx;
      exc_rd <= g_rd;
    end else if (exc_ack) exc_valid <= 1'b0;

  // count every non-error retirement, including rd=0 discards
  always_ff @(posedge clk or posedge rst)
    if (rst) commit_cnt <= '0;
    else if (grant && !g_err) commit_cnt <= commit_cnt + 32'd1;
endmodule

// File: tb/tb_alu_commit_arbiter.sv
// tb_alu_commit_arbiter: scoreboard bench with ALU unit models and a rule-level reference model
module tb_alu_commit_arbiter;
  localparam int N = 4, XL = 32, RW = 5;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] alu_valid, alu_error, alu_clear;
  logic [N*XL-1:0] alu_res;
  logic [N*RW-1:0] alu_rd;
  logic flush = 1'b0, wb_stall = 1'b0, exc_ack = 1'b0;
  logic wb_en, exc_valid;
  logic [RW-1:0] wb_addr, exc_rd;
  logic [XL-1:0] wb_data;
  logic [1:0] exc_src;
  logic [31:0] commit_cnt;
  logic u_valid [N];
  logic [XL-1:0] u_res [N];
  logic [RW-1:0] u_rd [N];
  logic u_err [N];
  int errors = 0, checks = 0;
  logic [RW+XL-1:0] wq [$];
  logic [RW+XL-1:0] wexp;
  bit m_wb_en, m_exc;
  logic [RW-1:0] m_addr, m_rd;
  logic [XL-1:0] m_data;
  logic [31:0] m_cnt;
  int m_src, rr;
  logic [N-1:0] last_clr;
  logic [31:0] cnt_save;

  alu_commit_arbiter #(.N_ALU(N), .XLEN(XL), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_res(alu_res), .alu_rd(alu_rd),
    .alu_error(alu_error), .alu_clear(alu_clear), .flush(flush), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall), .exc_valid(exc_valid),
    .exc_src(exc_src), .exc_rd(exc_rd), .exc_ack(exc_ack), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  // pack the unit models onto the DUT buses
  always_comb begin
    alu_valid = '0;
    alu_error = '0;
    alu_res = '0;
    alu_rd = '0;
    for (int i = 0; i < N; i++) begin
      alu_valid[i] = u_valid[i];
      alu_error[i] = u_err[i] & u_valid[i];
      alu_res[i*XL +: XL] = u_res[i];
      alu_rd[i*RW +: RW] = u_rd[i];
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: every accepted write must match the oldest expected write
  always @(posedge clk)
    if (!rst && wb_en === 1'b1 && !wb_stall) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL wb_accept: got write %0h:%0h expected none", wb_addr, wb_data);
      end else begin
        wexp = wq.pop_front();
        if ({wb_addr, wb_data} !== wexp) begin
          errors++;
          $display("FAIL wb_accept: got %0h expected %0h", {wb_addr, wb_data}, wexp);
        end
      end
    end

  task automatic model_reset();
    m_wb_en = 0; m_exc = 0; m_addr = '0; m_rd = '0; m_data = '0; m_cnt = '0; m_src = 0; rr = 0;
  endtask

  task automatic put(int i, logic [XL-1:0] r, logic [RW-1:0] d, bit e);
    u_valid[i] = 1'b1; u_res[i] = r; u_rd[i] = d; u_err[i] = e;
  endtask

  // one clock: check registered outputs and the grant, advance the model, let units react
  task automatic step();
    logic [N-1:0] ce, vv, clr_s;
    int g;
    @(negedge clk);
    chk("wb_en", {63'd0, wb_en}, {63'd0, m_wb_en});
    if (m_wb_en) begin
      chk("wb_addr", 64'(wb_addr), 64'(m_addr));
      chk("wb_data", 64'(wb_data), 64'(m_data));
    end
    chk("exc_valid", {63'd0, exc_valid}, {63'd0, m_exc});
    if (m_exc) begin
      chk("exc_src", 64'(exc_src), 64'(m_src));
      chk("exc_rd", 64'(exc_rd), 64'(m_rd));
    end
    chk("commit_cnt", 64'(commit_cnt), 64'(m_cnt));
    g = -1;
    vv = '0;
    for (int i = 0; i < N; i++) vv[i] = u_valid[i];
    if ((!m_wb_en || !wb_stall) && !flush)
      for (int k = 0; k < N; k++) begin
        int j;
        j = (rr + k) % N;
        if (g < 0 && u_valid[j] && (!u_err[j] || !m_exc)) g = j;
      end
    ce = '0;
    if (flush) ce = vv;
    else if (g >= 0) ce[g] = 1'b1;
    chk("alu_clear", 64'(alu_clear), 64'(ce));
    clr_s = alu_clear;
    last_clr = alu_clear;
    if (m_wb_en && !wb_stall) wq.push_back({m_addr, m_data});
    if (flush) m_wb_en = 0;
    else if (!(m_wb_en && wb_stall)) begin
      m_wb_en = g >= 0 && !u_err[g] && u_rd[g] != 0;
      if (m_wb_en) begin
        m_addr = u_rd[g];
        m_data = u_res[g];
      end
    end
    if (g >= 0 && u_err[g]) begin
      m_exc = 1; m_src = g; m_rd = u_rd[g];
    end else if (exc_ack) m_exc = 0;
    if (g >= 0 && !u_err[g]) m_cnt++;
    if (g >= 0) rr = (g + 1) % N;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (clr_s[i]) u_valid[i] = 1'b0;
  endtask

  task automatic chk_reset_vals(string nm);
    chk({nm, "_wb_en"}, {63'd0, wb_en}, 64'd0);
    chk({nm, "_wb_addr"}, 64'(wb_addr), 64'd0);
    chk({nm, "_wb_data"}, 64'(wb_data), 64'd0);
    chk({nm, "_exc_valid"}, {63'd0, exc_valid}, 64'd0);
    chk({nm, "_exc_src"}, 64'(exc_src), 64'd0);
    chk({nm, "_exc_rd"}, 64'(exc_rd), 64'd0);
    chk({nm, "_commit_cnt"}, 64'(commit_cnt), 64'd0);
    chk({nm, "_alu_clear"}, 64'(alu_clear), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      u_valid[i] = 1'b0; u_res[i] = '0; u_rd[i] = '0; u_err[i] = 1'b0;
    end
    model_reset();
    last_clr = '0;
    repeat (2) @(posedge clk);
    #1;
    put(2, 32'hA5, 5'd7, 1'b0);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    // single result from unit 2
    step();
    chk("single_clear", 64'(last_clr), 64'b0100);
    chk("single_wb_en", {63'd0, wb_en}, 64'd1);
    chk("single_addr", 64'(wb_addr), 64'd7);
    chk("single_data", 64'(wb_data), 64'hA5);
    chk("single_cnt", 64'(commit_cnt), 64'd1);
    step();
    // async reset pulse restarts the pointer at 0
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) put(i, 32'h100 + i, 5'(i + 1), 1'b0);
    for (int k = 0; k < N; k++) begin
      step();
      chk("rr_order", 64'(last_clr), 64'(1 << k));
    end
    chk("rr_cnt", 64'(commit_cnt), 64'd4);
    // stall holds the write and blocks grants
    put(0, 32'h200, 5'd10, 1'b0);
    put(1, 32'h201, 5'd11, 1'b0);
    step();
    wb_stall = 1'b1;
    repeat (3) begin
      step();
      chk("stall_clear", 64'(last_clr), 64'd0);
      chk("stall_data", 64'(wb_data), 64'h200);
    end
    wb_stall = 1'b0;
    step();
    chk("stall_release_clear", 64'(last_clr), 64'b0010);
    step();
    // errors: second erroring unit waits, non-error unit still retires
    put(1, 32'hDEAD, 5'd9, 1'b1);
    step();
    chk("err_exc_valid", {63'd0, exc_valid}, 64'd1);
    chk("err_exc_src", 64'(exc_src), 64'd1);
    chk("err_exc_rd", 64'(exc_rd), 64'd9);
    chk("err_no_write", {63'd0, wb_en}, 64'd0);
    put(3, 32'hBEEF, 5'd12, 1'b1);
    put(2, 32'h300, 5'd4, 1'b0);
    step();
    chk("err_other_retired", 64'(last_clr), 64'b0100);
    step();
    chk("err_waits", 64'(last_clr), 64'd0);
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    step();
    chk("err2_src", 64'(exc_src), 64'd3);
    chk("err2_rd", 64'(exc_rd), 64'd12);
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    // flush while stalled
    put(1, 32'h400, 5'd20, 1'b0);
    step();
    put(0, 32'h500, 5'd21, 1'b0);
    put(3, 32'h503, 5'd22, 1'b0);
    wb_stall = 1'b1;
    flush = 1'b1;
    cnt_save = commit_cnt;
    step();
    flush = 1'b0;
    wb_stall = 1'b0;
    chk("flush_clear", 64'(last_clr), 64'b1001);
    chk("flush_wb_en", {63'd0, wb_en}, 64'd0);
    chk("flush_cnt", 64'(commit_cnt), 64'(cnt_save));
    // reset mid-stall, then an rd=0 result left pending in a unit
    put(2, 32'h600, 5'd6, 1'b0);
    step();
    wb_stall = 1'b1;
    step();
    put(0, 32'h55, 5'd0, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    wb_stall = 1'b0;
    step();
    chk("rd0_clear", 64'(last_clr), 64'b0001);
    chk("rd0_wb_en", {63'd0, wb_en}, 64'd0);
    chk("rd0_cnt", 64'(commit_cnt), 64'd1);
    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      wb_stall = $urandom_range(0, 9) < 3;
      flush = $urandom_range(0, 24) == 0;
      exc_ack = $urandom_range(0, 3) == 0;
      for (int i = 0; i < N; i++)
        if (!u_valid[i] && !last_clr[i] && $urandom_range(0, 1) == 1)
          put(i, $urandom, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom_range(0, 9) == 0);
      step();
    end
    wb_stall = 1'b0;
    flush = 1'b0;
    exc_ack = 1'b1;
    repeat (12) step();
    chk("queue_drained", 64'(wq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
